mips_multicycle_ctrl: RTL
=========================

# mips_multicycle_ctrl

Multicycle sequencing controller for the MIPS core. It steps each instruction through fetch, decode, execute, memory and write-back states, and drives the shared-ALU/shared-memory datapath select and enable lines one state at a time. It handles a stalling memory handshake (`mem_ready`) and a run/halt request. The single-cycle opcode decoder stays in the design for the single-cycle build; this block replaces it in the multicycle build.

## Interface
- No parameters; opcode and funct encodings come from `src/defines.vh`.
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  synchronous, active-high
- `run`  in  1  when low, controller parks in IDLE at the next instruction boundary
- `opcode`  in  6  IR[31:26], valid from DECODE onward
- `funct`  in  6  IR[5:0]
- `mem_ready`  in  1  memory completes the current access this cycle
- `PCWrite`, `PCWriteCond`, `BranchNe`, `IorD`, `IRWrite`, `MemRead`, `MemWrite`, `RegWrite`, `ALUSrcA`, `ExtOp`  out  1 each
- `PCSrc`  out  2  00 ALU result, 01 ALUOut, 10 jump target, 11 register A
- `ALUSrcB`  out  2  00 B, 01 const 4, 10 ext imm, 11 ext imm<<2
- `ALUOp`  out  2  00 add, 01 sub, 10 funct, 11 logic-immediate
- `RegDst`  out  2  00 rt, 01 rd, 10 $31
- `MemtoReg`  out  2  00 ALUOut, 01 MDR, 10 PC, 11 imm<<16
- `instr_done`  out  1  one-cycle pulse in the final cycle of each instruction
- `illegal`  out  1  sticky, set on an unknown opcode
- `state`  out  4  current state, for debug

## Operation
- Moore FSM. Outputs decode combinationally from `state`; FETCH and MEM_* states also gate their enables with `mem_ready`. Any signal not listed for a state is 0, except `ExtOp`, which defaults to 1.
- IDLE: all outputs 0. Moves to FETCH when `run`=1.
- FETCH: `MemRead`=1, `IorD`=0, `ALUSrcA`=0, `ALUSrcB`=01, `ALUOp`=00, `PCSrc`=00. `IRWrite` and `PCWrite` assert only while `mem_ready`=1. Holds in FETCH until `mem_ready`, then goes to DECODE.
- DECODE: `ALUSrcB`=11, `ALUOp`=00 (branch target into ALUOut). Next state:
  - RTYPE with funct 001000 goes to JR; other RTYPE goes to EXEC_R.
  - LW/SW go to MEM_ADDR.
  - BEQ/BNE go to BRANCH.
  - ADDI/ANDI/ORI/XORI go to EXEC_I.
  - LUI goes to I_WB.
  - J goes to JUMP; JAL goes to JAL.
  - Any other opcode goes to TRAP.
- EXEC_R: `ALUSrcA`=1, `ALUSrcB`=00, `ALUOp`=10, then R_WB. R_WB: `RegDst`=01, `MemtoReg`=00, `RegWrite`=1.
- EXEC_I: `ALUSrcA`=1, `ALUSrcB`=10. ADDI uses `ALUOp`=00. ANDI/ORI/XORI use `ALUOp`=11 with `ExtOp`=0. Then I_WB.
- I_WB: `RegDst`=00, `RegWrite`=1. `MemtoReg`=11 for LUI, 00 otherwise.
- MEM_ADDR: `ALUSrcA`=1, `ALUSrcB`=10, `ALUOp`=00. LW goes to MEM_READ; SW goes to MEM_WRITE.
- MEM_READ: `MemRead`=1, `IorD`=1. Holds until `mem_ready`, then MEM_WB. MEM_WB: `RegDst`=00, `MemtoReg`=01, `RegWrite`=1.
- MEM_WRITE: `MemWrite`=1, `IorD`=1. Holds until `mem_ready`.
- BRANCH: `ALUSrcA`=1, `ALUSrcB`=00, `ALUOp`=01, `PCWriteCond`=1, `PCSrc`=01. `BranchNe`=1 for BNE only.
- JUMP: `PCWrite`=1, `PCSrc`=10.
- JAL: same as JUMP, plus `RegWrite`=1, `RegDst`=10, `MemtoReg`=10. PC already holds PC+4 at this point.
- JR: `PCWrite`=1, `PCSrc`=11.
- Terminal states are R_WB, I_WB, MEM_WB, MEM_WRITE (on its `mem_ready` cycle), BRANCH, JUMP, JAL and JR. In a terminal state, `instr_done`=1 and the next state is FETCH if `run`=1, else IDLE.
- TRAP: all outputs 0 and `illegal`=1. Held until `reset`.

## Timing
- `reset` forces IDLE and clears `illegal` on the next edge. It wins over every other input, including mid-instruction and while waiting on memory; the partially executed instruction is abandoned with no further enables asserted.
- Latency, counted from FETCH entry with zero-wait memory (each memory wait cycle adds one):
  - branch, J, JAL, JR, LUI: 3 cycles
  - R-type, immediate ALU, SW: 4 cycles
  - LW: 5 cycles
- While a state waits on memory, `MemRead`/`MemWrite` stay asserted and stable, and `PCWrite`/`IRWrite` stay 0.
- `run` is sampled only in IDLE and in terminal states. Deasserting it mid-instruction never truncates the instruction.
- `mem_ready` is ignored outside FETCH, MEM_READ and MEM_WRITE.

## Test plan
- Reset, then `run`=1, `mem_ready`=1, fetch ADD (opcode 000000, funct 100000) -> states IDLE, FETCH, DECODE, EXEC_R, R_WB. `RegWrite`=1 with `RegDst`=01 in R_WB. `instr_done` pulses exactly once.
- LW with `mem_ready` low for 2 cycles in FETCH and 3 cycles in MEM_READ -> 10 cycles from FETCH entry. `IRWrite`/`PCWrite` pulse once, on the ready cycle. `MemtoReg`=01 in MEM_WB.
- BNE then BEQ -> 3 cycles each. `PCWriteCond`=1 and `PCSrc`=01 in BRANCH. `BranchNe`=1 only for BNE.
- JAL (000011), then JR (funct 001000), then ORI (001101) -> JAL state shows `RegDst`=10, `MemtoReg`=10, `PCSrc`=10. JR shows `PCSrc`=11. ORI shows `ExtOp`=0 and `ALUOp`=11 in EXEC_I.
- Opcode 111111 -> TRAP with `illegal`=1 held for 20 cycles. `reset` clears it and returns to IDLE.
- `run` dropped in MEM_ADDR of an SW -> the SW completes, then the FSM enters IDLE. Reset asserted mid-MEM_READ -> IDLE on the next edge with no `RegWrite`.

Source files
------------

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS sequencing controller: steps each instruction through
// fetch/decode/execute/memory/write-back and drives the shared datapath selects.
module mips_multicycle_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       BranchNe,
  output logic       IorD,
  output logic       IRWrite,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic       ExtOp,
  output logic [1:0] PCSrc,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] RegDst,
  output logic [1:0] MemtoReg,
  output logic       instr_done,
  output logic       illegal,
  output logic [3:0] state
);

  // Encodings match src/defines.vh.
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC_R, S_R_WB, S_EXEC_I, S_I_WB, S_MEM_ADDR,
    S_MEM_READ, S_MEM_WB, S_MEM_WRITE, S_BRANCH, S_JUMP, S_JAL, S_JR, S_TRAP
  } state_e;

  state_e state_q, state_d;
  logic   illegal_q, illegal_d;
  state_e term_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  assign term_next = run ? S_FETCH : S_IDLE;

  always_comb begin
    state_d     = state_q;
    illegal_d   = illegal_q;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    BranchNe    = 1'b0;
    IorD        = 1'b0;
    IRWrite     = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ExtOp       = 1'b1;
    PCSrc       = 2'b00;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    RegDst      = 2'b00;
    MemtoReg    = 2'b00;
    instr_done  = 1'b0;

    case (state_q)
      S_IDLE: begin
        ExtOp = 1'b0;
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        // IR and PC+4 commit only on the cycle memory actually returns data.
        if (mem_ready) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        case (opcode)
          OP_RTYPE:                   state_d = (funct == FN_JR) ? S_JR : S_EXEC_R;
          OP_LW, OP_SW:               state_d = S_MEM_ADDR;
          OP_BEQ, OP_BNE:             state_d = S_BRANCH;
          OP_ADDI, OP_ANDI, OP_ORI,
          OP_XORI:                    state_d = S_EXEC_I;
          OP_LUI:                     state_d = S_I_WB;
          OP_J:                       state_d = S_JUMP;
          OP_JAL:                     state_d = S_JAL;
          default: begin
            state_d   = S_TRAP;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_EXEC_R: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
        state_d = S_R_WB;
      end
      S_R_WB: begin
        RegDst     = 2'b01;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        state_d    = term_next;
      end
      S_EXEC_I: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        // Logical immediates are zero-extended; only ADDI sign-extends.
        if (opcode != OP_ADDI) begin
          ALUOp = 2'b11;
          ExtOp = 1'b0;
        end
        state_d = S_I_WB;
      end
      S_I_WB: begin
        RegWrite   = 1'b1;
        MemtoReg   = (opcode == OP_LUI) ? 2'b11 : 2'b00;
        instr_done = 1'b1;
        state_d    = term_next;
      end
      S_MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      end
      S_MEM_READ: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (mem_ready) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        MemtoReg   = 2'b01;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        state_d    = term_next;
      end
      S_MEM_WRITE: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        if (mem_ready) begin
          instr_done = 1'b1;
          state_d    = term_next;
        end
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSrc       = 2'b01;
        BranchNe    = (opcode == OP_BNE);
        instr_done  = 1'b1;
        state_d     = term_next;
      end
      S_JUMP: begin
        PCWrite    = 1'b1;
        PCSrc      = 2'b10;
        instr_done = 1'b1;
        state_d    = term_next;
      end
      S_JAL: begin
        // PC already holds PC+4 here, so it is the link value for $31.
        PCWrite    = 1'b1;
        PCSrc      = 2'b10;
        RegWrite   = 1'b1;
        RegDst     = 2'b10;
        MemtoReg   = 2'b10;
        instr_done = 1'b1;
        state_d    = term_next;
      end
      S_JR: begin
        PCWrite    = 1'b1;
        PCSrc      = 2'b11;
        instr_done = 1'b1;
        state_d    = term_next;
      end
      S_TRAP: begin
        ExtOp = 1'b0;
      end
      default: begin
        ExtOp   = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  assign illegal = illegal_q;
  assign state   = state_q;

endmodule
